logic_u: RTL and testbench

- Registered 8-bit (parameterizable) bitwise logic unit used as the logic slice of the datapath ALU.
- Two operands a, b; select {s1,s0} chooses AND, XOR, OR or NOT b.
- Result and status flags are captured on the clock edge after a valid input.
- Single clock domain. Asynchronous, active-high reset.

---
 rtl/logic_u.sv | 58 +++++
 tb/tb_logic_u.sv | 134 +++++++++++++
 2 files changed

// File: rtl/logic_u.sv
// logic_u: registered bitwise logic slice (AND/XOR/OR/NOT b) with one-cycle latency.
// Define LOGIC_U_FLAGS_EN to add the registered zero and parity flags.
module logic_u #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
`ifdef LOGIC_U_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q;

    always_comb out_d = s1 ? (s0 ? ~b : a | b) : (s0 ? a ^ b : a & b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) out_q <= out_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

`ifdef LOGIC_U_FLAGS_EN
    // Flags are computed from the next result so they land on the same edge as out.
    logic zero_q, parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else if (in_valid) begin
            zero_q   <= ~|out_d;
            parity_q <= ^out_d;
        end
    end

    assign zero   = zero_q;
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_u.sv
// tb_logic_u: randomized and directed checks of logic_u against a behavioural model.
module tb_logic_u;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         s1 = 1'b0;
    logic         s0 = 1'b0;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef LOGIC_U_FLAGS_EN
    logic         zero, parity;
`endif

    logic [W-1:0] exp_out = '0;
    logic         exp_v = 1'b0;
    int           checks = 0;
    int           errors = 0;

    logic_u #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .a(a),
        .b(b),
        .s1(s1),
        .s0(s0),
        .out(out),
        .out_valid(out_valid)
`ifdef LOGIC_U_FLAGS_EN
        ,
        .zero(zero),
        .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input int sel);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            case (sel)
                0: r[i] = x[i] && y[i];
                1: r[i] = x[i] != y[i];
                2: r[i] = x[i] || y[i];
                default: r[i] = !y[i];
            endcase
        end
        return r;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out"}, 64'(out), 64'(exp_out));
        check({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
`ifdef LOGIC_U_FLAGS_EN
        check({tag, ".zero"}, 64'(zero), 64'(exp_out == 0));
        check({tag, ".parity"}, 64'(parity), 64'($countones(exp_out) % 2));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [W-1:0] ai,
                        input logic [W-1:0] bi, input int sel);
        in_valid = v;
        a = ai;
        b = bi;
        {s1, s0} = 2'(sel);
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) exp_out = model(ai, bi, sel);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        exp_out = '0;
        exp_v = 1'b0;
        check_all(tag);
        in_valid = 1'b1;
        a = 8'hA5;
        b = 8'h3C;
        {s1, s0} = 2'b10;
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;
        step("and", 1, 8'b00110101, 8'b01100111, 0);
        check("and.lit", 64'(out), 64'(8'b00100101));
        step("xor", 1, 8'b00110101, 8'b01100111, 1);
        check("xor.lit", 64'(out), 64'(8'b01010010));
        step("or", 1, 8'b00110101, 8'b01100111, 2);
        check("or.lit", 64'(out), 64'(8'b01110111));
        step("not", 1, 8'b00110101, 8'b01100111, 3);
        check("not.lit", 64'(out), 64'(8'b10011000));
        step("hold", 0, 8'hFF, 8'h00, 0);
        check("hold.lit", 64'(out), 64'(8'b10011000));
        step("hold2", 0, 8'h12, 8'h34, 2);
        step("zero", 1, 8'h0F, 8'hF0, 0);
        step("nota", 1, 8'h5A, 8'hFF, 3);
        step("notb", 1, 8'hC3, 8'h00, 3);
        check("notb.lit", 64'(out), 64'(8'hFF));
        async_reset("rst_mid");
        for (int n = 0; n < 300; n++) begin
            step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            if (n % 97 == 50) async_reset("rst_rnd");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
